// File: rtl/program_loader_if.sv
// Command handshake and instruction-memory write bus shared by the program loader
// and whatever feeds it commands / receives its writes.
interface program_loader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_kind;
  logic [2:0]  cmd_funct3;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [12:0] cmd_imm;
  logic        cmd_last;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  cmd_valid, cmd_kind, cmd_funct3, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_kind, cmd_funct3, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Encodes OP-IMM / branch commands into RV32 words and writes them to consecutive
// instruction-memory addresses; an accepted command is staged one cycle before its write.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] encode_i(input logic [12:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
    return {imm[11:0], rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] encode_b(input logic [12:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // I-type needs imm to fit in 12 signed bits; B-type needs an even offset
  function automatic logic cmd_legal(input logic kind, input logic [12:0] imm);
    logic ok;
    if (kind == 1'b0) begin
      ok = (imm[12] == imm[11]);
    end else begin
      ok = (imm[0] == 1'b0);
    end
    return ok;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        pend_we_q, pend_we_d;
  logic        pend_last_q, pend_last_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_word_q, pend_word_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept_s;
  logic [31:0] word_s;
  logic        legal_s;

  // Next-state, staging and registered-output computation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    pend_we_d   = pend_we_q;
    pend_last_d = pend_last_q;
    pend_addr_d = pend_addr_q;
    pend_word_d = pend_word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    accept_s = bus.cmd_valid && cmd_ready_q;
    legal_s  = cmd_legal(bus.cmd_kind, bus.cmd_imm);
    if (bus.cmd_kind == 1'b0) begin
      word_s = encode_i(bus.cmd_imm, bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd);
    end else begin
      word_s = encode_b(bus.cmd_imm, bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3);
    end

    if (pend_q && pend_we_q) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = pend_addr_q;
      mem_wdata_d = pend_word_q;
    end else begin
      mem_we_d    = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = BASE_ADDR;
          cnt_d   = 16'd0;
          err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (pend_q && pend_last_q) begin
          state_d = S_DONE;
        end else if (cnt_q >= MAX_W) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (accept_s) begin
          pend_d      = 1'b1;
          pend_last_d = bus.cmd_last;
          // Address/count advance at acceptance so back-to-back commands see fresh values
          if (legal_s) begin
            pend_we_d   = 1'b1;
            pend_addr_d = addr_q;
            pend_word_d = word_s;
            addr_d      = addr_q + 32'd4;
            cnt_d       = cnt_q + 16'd1;
          end else begin
            pend_we_d   = 1'b0;
            err_d       = 1'b1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_LOAD) && (cnt_d < MAX_W) && !(pend_d && pend_last_d);
    busy_d      = (state_d == S_LOAD) || pend_d;
    done_d      = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE_ADDR;
      cnt_q       <= 16'd0;
      pend_q      <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_last_q <= 1'b0;
      pend_addr_q <= BASE_ADDR;
      pend_word_q <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_we_q   <= pend_we_d;
      pend_last_q <= pend_last_d;
      pend_addr_q <= pend_addr_d;
      pend_word_q <= pend_word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one default instance and one with MAX_WORDS=2.
module tb_program_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic busy, done, err;
  logic busy2, done2, err2;
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we_cnt2 = 0;
  int base_cnt;

  program_loader_if b();
  program_loader_if b2();

  program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(b), .busy(busy), .done(done), .err(err));

  program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(b2), .busy(busy2), .done(done2), .err(err2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b.mem_we === 1'b1) we_cnt <= we_cnt + 1;
    if (b2.mem_we === 1'b1) we_cnt2 <= we_cnt2 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic kind, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] imm, input logic last);
    b.cmd_valid = 1'b1; b.cmd_kind = kind; b.cmd_funct3 = f3; b.cmd_rd = rd;
    b.cmd_rs1 = rs1; b.cmd_rs2 = rs2; b.cmd_imm = imm; b.cmd_last = last;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (b.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h expected 0", b.cmd_ready); end
    checks++; if (b.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h expected 0", b.mem_we); end
    checks++; if (b.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", b.mem_addr); end
    checks++; if (b.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", b.mem_wdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, err}); end
    checks++; if ({busy2, done2, err2, b2.cmd_ready} !== 4'b0000) begin errors++; $display("FAIL reset_status2: got %b expected 0000", {busy2, done2, err2, b2.cmd_ready}); end
  endtask

  task automatic test_itype();
    do_start();
    checks++; if ({busy, b.cmd_ready} !== 2'b11) begin errors++; $display("FAIL load_entry: got %b expected 11", {busy, b.cmd_ready}); end
    drive_cmd(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    checks++; if (b.mem_we !== 1'b0) begin errors++; $display("FAIL itype_staged: got %0h expected 0", b.mem_we); end
    tick();
    checks++; if (b.mem_we !== 1'b1) begin errors++; $display("FAIL itype_we: got %0h expected 1", b.mem_we); end
    checks++; if (b.mem_addr !== 32'h0) begin errors++; $display("FAIL itype_addr: got %0h expected 0", b.mem_addr); end
    checks++; if (b.mem_wdata !== 32'h0050_0093) begin errors++; $display("FAIL itype_wdata: got %0h expected 500093", b.mem_wdata); end
    tick();
    checks++; if (b.mem_we !== 1'b0) begin errors++; $display("FAIL itype_one_pulse: got %0h expected 0", b.mem_we); end
    checks++; if (b.mem_wdata !== 32'h0050_0093) begin errors++; $display("FAIL itype_hold: got %0h expected 500093", b.mem_wdata); end
  endtask

  task automatic test_btype();
    drive_cmd(1'b1, 3'd1, 5'd0, 5'd1, 5'd0, 13'h1FFC, 1'b1);
    tick(); b.cmd_valid = 1'b0;
    tick();
    checks++; if (b.mem_we !== 1'b1) begin errors++; $display("FAIL btype_we: got %0h expected 1", b.mem_we); end
    checks++; if (b.mem_addr !== 32'h4) begin errors++; $display("FAIL btype_addr: got %0h expected 4", b.mem_addr); end
    checks++; if (b.mem_wdata !== 32'hFE00_9EE3) begin errors++; $display("FAIL btype_wdata: got %0h expected fe009ee3", b.mem_wdata); end
    tick();
    checks++; if ({done, busy, err, b.cmd_ready} !== 4'b1000) begin errors++; $display("FAIL btype_done: got %b expected 1000", {done, busy, err, b.cmd_ready}); end
  endtask

  task automatic test_illegal();
    do_start();
    base_cnt = we_cnt;
    drive_cmd(1'b0, 3'd0, 5'd2, 5'd3, 5'd0, 13'h0800, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_i_err: got %0h expected 1", err); end
    drive_cmd(1'b1, 3'd0, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    tick(); tick();
    checks++; if (we_cnt - base_cnt !== 0) begin errors++; $display("FAIL illegal_no_write: got %0d expected 0", we_cnt - base_cnt); end
    checks++; if ({busy, err} !== 2'b11) begin errors++; $display("FAIL illegal_sticky: got %b expected 11", {busy, err}); end
    drive_cmd(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    tick();
    checks++; if ({b.mem_we, b.mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL illegal_addr_kept: got %0h expected 100000000", {b.mem_we, b.mem_addr}); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err_held: got %0h expected 1", err); end
  endtask

  task automatic test_back_to_back();
    start2 = 1'b1; tick(); start2 = 1'b0;
    b2.cmd_valid = 1'b1; b2.cmd_kind = 1'b0; b2.cmd_funct3 = 3'd0; b2.cmd_rd = 5'd1;
    b2.cmd_rs1 = 5'd0; b2.cmd_rs2 = 5'd0; b2.cmd_imm = 13'd1; b2.cmd_last = 1'b0;
    tick();
    b2.cmd_imm = 13'd2;
    checks++; if (b2.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %0h expected 1", b2.cmd_ready); end
    tick();
    b2.cmd_imm = 13'd3;
    checks++; if (b2.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready3: got %0h expected 0", b2.cmd_ready); end
    checks++; if ({b2.mem_we, b2.mem_addr, b2.mem_wdata} !== {1'b1, 32'h0, 32'h0010_0093}) begin errors++; $display("FAIL b2b_write1: got %0h expected 1_00000000_00100093", {b2.mem_we, b2.mem_addr, b2.mem_wdata}); end
    tick();
    checks++; if ({b2.mem_we, b2.mem_addr, b2.mem_wdata} !== {1'b1, 32'h4, 32'h0020_0093}) begin errors++; $display("FAIL b2b_write2: got %0h expected 1_00000004_00200093", {b2.mem_we, b2.mem_addr, b2.mem_wdata}); end
    checks++; if ({done2, err2, b2.cmd_ready} !== 3'b110) begin errors++; $display("FAIL b2b_status: got %b expected 110", {done2, err2, b2.cmd_ready}); end
    tick(); tick();
    b2.cmd_valid = 1'b0;
    checks++; if (we_cnt2 !== 2) begin errors++; $display("FAIL b2b_write_count: got %0d expected 2", we_cnt2); end
  endtask

  task automatic test_reset_pending();
    do_start();
    drive_cmd(1'b0, 3'd0, 5'd7, 5'd0, 5'd0, 13'd9, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    base_cnt = we_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if ({b.mem_we, b.cmd_ready, busy, done, err} !== 5'b00000) begin errors++; $display("FAIL rstpend_status: got %b expected 00000", {b.mem_we, b.cmd_ready, busy, done, err}); end
    checks++; if ({b.mem_addr, b.mem_wdata} !== 64'h0) begin errors++; $display("FAIL rstpend_bus: got %0h expected 0", {b.mem_addr, b.mem_wdata}); end
    tick();
    checks++; if (we_cnt - base_cnt !== 0) begin errors++; $display("FAIL rstpend_dropped: got %0d expected 0", we_cnt - base_cnt); end
    do_start();
    drive_cmd(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    tick();
    checks++; if ({b.mem_we, b.mem_addr, b.mem_wdata} !== {1'b1, 32'h0, 32'h0050_0093}) begin errors++; $display("FAIL rstpend_restart: got %0h expected 1_00000000_00500093", {b.mem_we, b.mem_addr, b.mem_wdata}); end
  endtask

  task automatic test_start_in_load();
    drive_cmd(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 13'd6, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    do_start();
    checks++; if ({b.mem_we, b.mem_addr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL startload_write: got %0h expected 100000004", {b.mem_we, b.mem_addr}); end
    drive_cmd(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 13'd7, 1'b0);
    tick(); b.cmd_valid = 1'b0;
    tick();
    checks++; if ({b.mem_we, b.mem_addr} !== {1'b1, 32'h8}) begin errors++; $display("FAIL startload_ignored: got %0h expected 100000008", {b.mem_we, b.mem_addr}); end
  endtask

  task automatic test_start_in_done();
    drive_cmd(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 13'h0FFF, 1'b1);
    tick(); b.cmd_valid = 1'b0;
    tick(); tick();
    checks++; if ({done, err, busy} !== 3'b110) begin errors++; $display("FAIL done_illegal_last: got %b expected 110", {done, err, busy}); end
    do_start();
    checks++; if ({done, err, busy} !== 3'b001) begin errors++; $display("FAIL done_restart: got %b expected 001", {done, err, busy}); end
    drive_cmd(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
    tick(); b.cmd_valid = 1'b0;
    tick();
    checks++; if ({b.mem_we, b.mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL done_base_write: got %0h expected 100000000", {b.mem_we, b.mem_addr}); end
  endtask

  initial begin
    b.cmd_valid = 1'b0; b.cmd_kind = 1'b0; b.cmd_funct3 = 3'd0; b.cmd_rd = 5'd0;
    b.cmd_rs1 = 5'd0; b.cmd_rs2 = 5'd0; b.cmd_imm = 13'd0; b.cmd_last = 1'b0;
    b2.cmd_valid = 1'b0; b2.cmd_kind = 1'b0; b2.cmd_funct3 = 3'd0; b2.cmd_rd = 5'd0;
    b2.cmd_rs1 = 5'd0; b2.cmd_rs2 = 5'd0; b2.cmd_imm = 13'd0; b2.cmd_last = 1'b0;
    #1;
    test_reset();
    test_itype();
    test_btype();
    test_illegal();
    test_back_to_back();
    test_reset_pending();
    test_start_in_load();
    test_start_in_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first instruction word written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 256, meaning the maximum number of words written per load (range 1..65535).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 The block SHALL have port cmd_valid  input  1  a command is present.
REQ-007 The block SHALL have port cmd_ready  output  1  the block accepts a command this cycle.
REQ-008 The block SHALL have port cmd_kind  input  1  instruction kind: 0 = OP-IMM I-type (opcode 7'd19), 1 = branch B-type (opcode 7'd99).
REQ-009 The block SHALL have the following command-field ports: cmd_funct3 input 3; cmd_rd input 5; cmd_rs1 input 5; cmd_rs2 input 5.
REQ-010 The block SHALL have port cmd_imm  input  13  two's-complement immediate.
REQ-011 The block SHALL have port cmd_last  input  1  marks the final command of the program.
REQ-012 The block SHALL have the following instruction-memory write ports: mem_we output 1; mem_addr output 32 (byte address); mem_wdata output 32.
REQ-013 The block SHALL have the following status ports: busy output 1; done output 1; err output 1 (sticky).

Function
REQ-014 The block SHALL implement states IDLE, LOAD and DONE, plus a write-address register and a 16-bit word counter.
REQ-015 In IDLE, cmd_ready SHALL be 0; on start=1 the block SHALL go to LOAD, set the address register to BASE_ADDR, clear the counter, and clear err and done.
REQ-016 In LOAD, cmd_ready SHALL equal 1 while counter < MAX_WORDS; a command is accepted only when cmd_valid && cmd_ready.
REQ-017 Commands SHALL be held stable by the sender while cmd_valid=1 && cmd_ready=0; the block SHALL not depend on cmd fields in any other cycle.
REQ-018 An I-type command SHALL encode as {imm[11:0], rs1, funct3, rd, 7'b0010011}, and is legal only if cmd_imm is in -2048..2047.
REQ-019 A B-type command SHALL encode as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}, and is legal only if imm[0]=0; cmd_rd SHALL be ignored.
REQ-020 For each accepted legal command, the block SHALL drive mem_we=1 for exactly one cycle on the next cycle, with mem_wdata set to the encoded word and mem_addr set to the current address, then add 4 to the address and 1 to the counter.
REQ-021 An accepted illegal command SHALL be consumed, produce no write, leave the address and counter unchanged, and set err=1.
REQ-022 An accepted command with cmd_last=1 SHALL move the block to DONE in the same cycle its write (if any) is issued.
REQ-023 When the counter reaches MAX_WORDS without cmd_last, the block SHALL set err=1 and go to DONE; the extra command SHALL not be accepted.
REQ-024 In DONE, done SHALL be 1 and cmd_ready SHALL be 0; on start=1 the block SHALL behave as REQ-015.
REQ-025 start SHALL be ignored while in LOAD.
REQ-026 busy SHALL be 1 exactly while in LOAD or while a write pulse is pending.
REQ-027 When mem_we=0, mem_addr and mem_wdata SHALL hold their last values.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE, regardless of state, including during a pending write.
REQ-029 On reset, outputs SHALL be: cmd_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, counter=0; any pending write pulse SHALL be dropped.
REQ-030 rst SHALL take priority over start and over any handshake in the same cycle.

Verification
REQ-031 The bench SHALL cover: start; then an I-type command with rd=1, rs1=0, funct3=0, imm=5, last=0 -> one cycle later mem_we=1, mem_addr=0x0, mem_wdata=0x00500093.
REQ-032 The bench SHALL cover: a following B-type command with rs1=1, rs2=0, funct3=1, imm=-4 (13'h1FFC), last=1 -> mem_we=1, mem_addr=0x4, mem_wdata=0xFE009EE3; the next cycle done=1, busy=0, err=0.
REQ-033 The bench SHALL cover: an I-type command with imm=2048, then a B-type command with imm=3 -> no mem_we pulses, address unchanged, err=1 held until the next start.
REQ-034 The bench SHALL cover: MAX_WORDS=2 with 3 back-to-back valid commands, none marked last -> exactly 2 writes (0x0, 0x4), cmd_ready=0 for the third, err=1, done=1.
REQ-035 The bench SHALL cover: rst asserted in the cycle after a command is accepted -> no mem_we pulse, IDLE, all outputs at reset values; a new start then writes to BASE_ADDR.
REQ-036 The bench SHALL cover: start pulsed in LOAD -> ignored; start in DONE -> err and done cleared, and the next write goes to BASE_ADDR.
